// File: rtl/weight_load_sequencer_pkg.sv
// weight_seq_pkg: shared types and helpers for the weight load sequencer.
//   state_t   - FSM state encoding
//   filt_base - first BRAM address a filter's read sweep starts from
package weight_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_PAD   = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Start address of filter f: base + f*K, moved to the last weight when
    // reading in reverse. Computed at 32 bits; the caller truncates to the
    // BRAM address width, which gives the modulo-2^ADDR_W wrap.
    function automatic logic [31:0] filt_base(input logic [31:0] base,
                                              input logic [31:0] f,
                                              input logic [31:0] k,
                                              input logic        rev);
        logic [31:0] b;
        b = base + f * k;
        if (rev) b = b + k - 32'd1;
        return b;
    endfunction

endpackage

// File: rtl/weight_load_sequencer_if.sv
// weight_load_sequencer_if: BRAM read port, shift-chain control and the
// per-filter handshake between the sequencer and the weight datapath.
//   rd_en / rd_addr  - weight BRAM read enable and address
//   shift_en         - per-lane shift enable (all bits identical)
//   data_sel         - 1 = BRAM data, 0 = zero into the chain
//   filter_loaded    - chain holds a complete filter
//   filter_ack       - consumer has used the loaded filter
// master = sequencer, slave = BRAM / shift-chain / consumer side.
interface weight_load_sequencer_if
    import weight_seq_pkg::*;
#(
    parameter int DIM    = 16,
    parameter int ADDR_W = 10
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DIM-1:0]    shift_en;
    logic              data_sel;
    logic              filter_loaded;
    logic              filter_ack;

    modport master (
        output rd_en, rd_addr, shift_en, data_sel, filter_loaded,
        input  filter_ack
    );

    modport slave (
        input  rd_en, rd_addr, shift_en, data_sel, filter_loaded,
        output filter_ack
    );
endinterface

// File: rtl/weight_load_sequencer_rd_valid_pipe.sv
// rd_valid_pipe: delays the BRAM read enable by the read latency so that the
// delayed bit marks the cycle the read data is on the BRAM output.
//   clk, rst - clock, asynchronous active-high reset
//   flush    - synchronously clears every stage (abort)
//   vld_in   - read issued this cycle
//   vld_out  - read data valid this cycle
module rd_valid_pipe
    import weight_seq_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic vld_in,
    output logic vld_out
);
    logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;

    always_comb begin
        vld_pipe_d = '0;
        if (!flush) begin
            vld_pipe_d[0] = vld_in;
            for (int i = 1; i < RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= vld_pipe_d;
    end

    assign vld_out = vld_pipe_q[RD_LAT-1];
endmodule

// File: rtl/weight_load_sequencer.sv
// weight_load_sequencer: streams K weights per filter from the weight BRAM
// into the DIM-lane shift chain, zero-pads to exactly DIM shifts, then holds
// the filter until the consumer acks it; repeats for F filters.
//   clk, rst        - clock, asynchronous active-high reset
//   start           - pulse, latches config (IDLE only)
//   abort           - return to IDLE next cycle, flush read pipe
//   kernel_size     - K, legal 1..DIM
//   num_filters     - F, legal >= 1
//   base_addr       - address of filter 0 weight 0
//   reverse         - read each filter's weights last-to-first
//   wl              - BRAM / shift-chain / handshake bundle (master side)
//   busy            - state != IDLE
//   done            - pulse after last filter ack
//   cfg_err         - pulse when start carries an illegal config
module weight_load_sequencer
    import weight_seq_pkg::*;
#(
    parameter int DIM    = 16,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1,
    parameter int FILT_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [$clog2(DIM):0]    kernel_size,
    input  logic [FILT_W-1:0]       num_filters,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    reverse,
    weight_load_sequencer_if.master wl,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);
    localparam int KW    = $clog2(DIM) + 1;
    localparam int CNT_W = $clog2(DIM + RD_LAT) + 1;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [FILT_W-1:0] nf_q, nf_d;
    logic [FILT_W-1:0] f_q, f_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              rev_q, rev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;   // read index in READ, stage count in DRAIN, zeros in PAD
    logic              cfg_err_q, cfg_err_d;

    logic              cfg_ok;
    logic              rd_en_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              zero_sel_c;
    logic              loaded_c;
    logic              done_c;
    logic              vld_out;

    assign cfg_ok = (kernel_size != '0) && (32'(kernel_size) <= 32'(DIM)) &&
                    (num_filters != '0);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        nf_d       = nf_q;
        f_d        = f_q;
        base_d     = base_q;
        rev_d      = rev_q;
        cnt_d      = cnt_q;
        cfg_err_d  = 1'b0;
        rd_en_c    = 1'b0;
        rd_addr_c  = '0;
        zero_sel_c = 1'b0;
        loaded_c   = 1'b0;
        done_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        k_d     = kernel_size;
                        nf_d    = num_filters;
                        base_d  = base_addr;
                        rev_d   = reverse;
                        f_d     = '0;
                        cnt_d   = '0;
                        state_d = S_READ;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                rd_en_c   = 1'b1;
                rd_addr_c = ADDR_W'(filt_base(32'(base_q), 32'(f_q), 32'(k_q), rev_q) +
                                    (rev_q ? (32'd0 - 32'(cnt_q)) : 32'(cnt_q)));
                if (32'(cnt_q) == 32'(k_q) - 32'd1) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Wait out the read latency so the last data shift lands before
            // any zero is pushed.
            S_DRAIN: begin
                if (32'(cnt_q) == 32'(RD_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = (32'(k_q) == 32'(DIM)) ? S_HOLD : S_PAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PAD: begin
                zero_sel_c = 1'b1;
                if (32'(cnt_q) == 32'(DIM) - 32'(k_q) - 32'd1) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                loaded_c = 1'b1;
                if (wl.filter_ack) begin
                    if (f_q == nf_q - FILT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        f_d     = f_q + FILT_W'(1);
                        cnt_d   = '0;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                done_c     = 1'b1;
                zero_sel_c = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over any same-cycle start or ack.
        if (abort) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            f_d       = '0;
            cfg_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            nf_q      <= '0;
            f_q       <= '0;
            base_q    <= '0;
            rev_q     <= 1'b0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            nf_q      <= nf_d;
            f_q       <= f_d;
            base_q    <= base_d;
            rev_q     <= rev_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    rd_valid_pipe #(.RD_LAT(RD_LAT)) u_rd_valid_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort),
        .vld_in  (rd_en_c),
        .vld_out (vld_out)
    );

    assign wl.rd_en         = rd_en_c;
    assign wl.rd_addr       = rd_addr_c;
    assign wl.shift_en      = {DIM{vld_out || (state_q == S_PAD)}};
    // Returning data always selects BRAM, whatever the state.
    assign wl.data_sel      = vld_out || !zero_sel_c;
    assign wl.filter_loaded = loaded_c;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_c;
    assign cfg_err          = cfg_err_q;
endmodule

// File: tb/tb_weight_load_sequencer.sv
// Bench for weight_load_sequencer: two instances (RD_LAT=1 and RD_LAT=2)
// share one stimulus stream; each is checked cycle by cycle against a
// per-lane model that tracks only mode, filter index and the cycle offset t
// within the current filter load (t=1 is the first read cycle).
module tb_weight_load_sequencer;
    localparam int DIM    = 16;
    localparam int ADDR_W = 10;
    localparam int FILT_W = 6;
    localparam int KW     = $clog2(DIM) + 1;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              reverse = 1'b0;
    logic              filter_ack = 1'b0;
    logic [KW-1:0]     kernel_size = '0;
    logic [FILT_W-1:0] num_filters = '0;
    logic [ADDR_W-1:0] base_addr = '0;

    weight_load_sequencer_if #(.DIM(DIM), .ADDR_W(ADDR_W)) wl0 ();
    weight_load_sequencer_if #(.DIM(DIM), .ADDR_W(ADDR_W)) wl1 ();
    assign wl0.filter_ack = filter_ack;
    assign wl1.filter_ack = filter_ack;

    logic              o_busy [2];
    logic              o_done [2];
    logic              o_err  [2];
    logic              o_rd_en [2];
    logic [ADDR_W-1:0] o_addr [2];
    logic [DIM-1:0]    o_sh   [2];
    logic              o_sel  [2];
    logic              o_ld   [2];

    assign o_rd_en[0] = wl0.rd_en;    assign o_rd_en[1] = wl1.rd_en;
    assign o_addr[0]  = wl0.rd_addr;  assign o_addr[1]  = wl1.rd_addr;
    assign o_sh[0]    = wl0.shift_en; assign o_sh[1]    = wl1.shift_en;
    assign o_sel[0]   = wl0.data_sel; assign o_sel[1]   = wl1.data_sel;
    assign o_ld[0]    = wl0.filter_loaded;
    assign o_ld[1]    = wl1.filter_loaded;

    weight_load_sequencer #(.DIM(DIM), .ADDR_W(ADDR_W), .RD_LAT(1), .FILT_W(FILT_W)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .kernel_size(kernel_size),
        .num_filters(num_filters), .base_addr(base_addr), .reverse(reverse), .wl(wl0),
        .busy(o_busy[0]), .done(o_done[0]), .cfg_err(o_err[0])
    );

    weight_load_sequencer #(.DIM(DIM), .ADDR_W(ADDR_W), .RD_LAT(2), .FILT_W(FILT_W)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .kernel_size(kernel_size),
        .num_filters(num_filters), .base_addr(base_addr), .reverse(reverse), .wl(wl1),
        .busy(o_busy[1]), .done(o_done[1]), .cfg_err(o_err[1])
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int m_mode [2];
    int m_t    [2];
    int m_f    [2];
    int m_k    [2];
    int m_nf   [2];
    int m_base [2];
    bit m_rev  [2];
    bit m_err  [2];
    int sh_cnt [2];

    task automatic chk(input string tag, input int lane, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s lane%0d @%0t: observed %0h expected %0h", tag, lane, $time, obs, exp);
        end
    endtask

    // Model state advance at a clock edge, using the inputs sampled there.
    task automatic model_edge(input int i);
        int lat;
        lat = i + 1;
        m_err[i] = 1'b0;
        if (rst || abort) begin
            m_mode[i] = M_IDLE;
        end else if (m_mode[i] == M_IDLE) begin
            if (start) begin
                if (kernel_size >= 1 && kernel_size <= DIM && num_filters >= 1) begin
                    m_k[i]    = int'(kernel_size);
                    m_nf[i]   = int'(num_filters);
                    m_base[i] = int'(base_addr);
                    m_rev[i]  = reverse;
                    m_f[i]    = 0;
                    m_t[i]    = 1;
                    sh_cnt[i] = 0;
                    m_mode[i] = M_LOAD;
                end else begin
                    m_err[i] = 1'b1;
                end
            end
        end else if (m_mode[i] == M_DONE) begin
            m_mode[i] = M_IDLE;
        end else if (m_t[i] <= DIM + lat) begin
            m_t[i]++;
        end else if (filter_ack) begin
            if (m_f[i] == m_nf[i] - 1) begin
                m_mode[i] = M_DONE;
            end else begin
                m_f[i]++;
                m_t[i]    = 1;
                sh_cnt[i] = 0;
            end
        end
    endtask

    task automatic check_lane(input int i);
        int lat, t, k;
        bit ld_ph, rd, sh, pad, ld;
        logic [31:0] addr;
        lat   = i + 1;
        t     = m_t[i];
        k     = m_k[i];
        ld_ph = (m_mode[i] == M_LOAD);
        rd    = ld_ph && t >= 1 && t <= k;
        sh    = ld_ph && t >= 1 + lat && t <= DIM + lat;
        pad   = ld_ph && t >= k + lat + 1 && t <= DIM + lat;
        ld    = ld_ph && t > DIM + lat;
        chk("rd_en", i, 32'(o_rd_en[i]), 32'(rd));
        if (rd) begin
            addr = 32'((m_base[i] + m_f[i] * k + (m_rev[i] ? k - t : t - 1)) % (1 << ADDR_W));
            chk("rd_addr", i, 32'(o_addr[i]), addr);
        end
        chk("shift_en", i, 32'(o_sh[i]), 32'({DIM{sh}}));
        chk("data_sel", i, 32'(o_sel[i]), 32'(!(m_mode[i] == M_DONE || pad)));
        chk("filter_loaded", i, 32'(o_ld[i]), 32'(ld));
        chk("busy", i, 32'(o_busy[i]), 32'(m_mode[i] != M_IDLE));
        chk("done", i, 32'(o_done[i]), 32'(m_mode[i] == M_DONE));
        chk("cfg_err", i, 32'(o_err[i]), 32'(m_err[i]));
        if (o_sh[i][0] === 1'b1) sh_cnt[i]++;
        if (ld_ph && t == DIM + lat) chk("shifts_per_filter", i, 32'(sh_cnt[i]), 32'(DIM));
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i);
        #1;
        for (int i = 0; i < 2; i++) check_lane(i);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic launch(input int k, input int f, input int b, input bit r);
        kernel_size = KW'(k);
        num_filters = FILT_W'(f);
        base_addr   = ADDR_W'(b);
        reverse     = r;
        start       = 1'b1;
        step();
    endtask

    task automatic ack_pulse();
        filter_ack = 1'b1;
        step();
        filter_ack = 1'b0;
    endtask

    task automatic chk_addr0(input string tag);
        for (int i = 0; i < 2; i++) chk(tag, i, 32'(o_addr[i]), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        // Reset state
        run(2);
        chk_addr0("reset_rd_addr");
        rst = 1'b0;
        step();

        // K=5 F=1 forward, base 0x10
        launch(5, 1, 'h10, 1'b0);
        run(22);
        ack_pulse();
        run(3);

        // K=16 F=2 reverse: no PAD, long HOLD before each ack
        launch(16, 2, 0, 1'b1);
        run(25);
        ack_pulse();
        run(25);
        ack_pulse();
        run(3);

        // K=1 F=3
        launch(1, 3, 'h40, 1'b0);
        repeat (3) begin
            run(20);
            ack_pulse();
        end
        run(3);

        // Illegal configs
        launch(0, 1, 'h20, 1'b0);  run(2);
        launch(17, 1, 'h20, 1'b0); run(2);
        launch(4, 0, 'h20, 1'b0);  run(2);

        // Abort mid-PAD of filter 1 of 3, then a fresh start
        launch(4, 3, 'h100, 1'b0);
        run(22);
        ack_pulse();
        run(8);
        abort = 1'b1;
        step();
        chk_addr0("abort_rd_addr");
        step();
        launch(3, 1, 'h200, 1'b1);
        run(22);
        ack_pulse();
        run(3);

        // Address wrap; start during HOLD is ignored
        launch(4, 2, 'h3FE, 1'b0);
        run(20);
        kernel_size = KW'(2);
        num_filters = FILT_W'(1);
        base_addr   = '0;
        start       = 1'b1;
        step();
        run(3);
        ack_pulse();
        run(22);
        ack_pulse();
        run(3);

        // Asynchronous reset mid-read
        launch(8, 2, 'h55, 1'b0);
        run(3);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE;
            m_err[i]  = 1'b0;
            check_lane(i);
        end
        chk_addr0("async_rst_rd_addr");
        step();
        rst = 1'b0;
        step();

        // Randomized runs
        for (int r = 0; r < 30; r++) begin
            launch(int'($urandom_range(0, 20)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
            cyc = 0;
            while ((m_mode[0] != M_IDLE || m_mode[1] != M_IDLE) && cyc < 600) begin
                filter_ack = ($urandom_range(0, 3) == 0);
                if (m_mode[0] != M_IDLE && m_mode[1] != M_IDLE && $urandom_range(0, 9) == 0) begin
                    start       = 1'b1;
                    kernel_size = KW'($urandom_range(0, 20));
                    num_filters = FILT_W'($urandom_range(0, 4));
                    base_addr   = ADDR_W'($urandom_range(0, 1023));
                    reverse     = 1'($urandom_range(0, 1));
                end
                abort = ($urandom_range(0, 299) == 0);
                step();
                cyc++;
            end
            filter_ack = 1'b0;
            chk("run_completes", 0, 32'(cyc < 600), 32'd1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
